// File: rtl/disp_scan_sched.sv
// Six-digit seven-segment scan scheduler: multiplexes the digit selects and
// latches one whole frame per scan from either the timer or the message overlay.
module disp_scan_sched #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 42
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic [23:0] tmr_data,
  input  logic        tmr_valid,
  output logic        tmr_ack,
  input  logic [23:0] msg_data,
  input  logic        msg_req,
  output logic        msg_ack,
  input  logic [5:0]  blink_mask,
  output logic [5:0]  sel,
  output logic [7:0]  led,
  output logic        frame_start,
  output logic        active_src
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [23:0]   frame_buf;
  logic [5:0]    mask_buf;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick;
  logic          boundary;
  logic [2:0]    idx_nx;
  logic [23:0]   buf_nx;
  logic [5:0]    mask_nx;
  logic [BW-1:0] cnt_nx;
  logic          phase_nx;
  logic          src_nx;
  logic          tack_nx;
  logic          mack_nx;
  logic [5:0]    sel_nx;
  logic [7:0]    led_nx;

  function automatic logic [3:0] pick_nibble(input logic [23:0] f, input logic [2:0] i);
    logic [3:0] n;
    case (i)
      3'd0:    n = f[23:20];
      3'd1:    n = f[19:16];
      3'd2:    n = f[15:12];
      3'd3:    n = f[11:8];
      3'd4:    n = f[7:4];
      3'd5:    n = f[3:0];
      default: n = 4'hA;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hB:    s = 8'h86;
      4'hC:    s = 8'hAB;
      4'hD:    s = 8'hA1;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (prescaler == PS_MAX);
    boundary = tick && (idx == 3'd5);
    idx_nx   = idx;
    buf_nx   = frame_buf;
    mask_nx  = mask_buf;
    cnt_nx   = blink_cnt;
    phase_nx = blink_phase;
    src_nx   = active_src;
    tack_nx  = 1'b0;
    mack_nx  = 1'b0;

    if (tick) begin
      idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end

    if (boundary) begin
      if (msg_req) begin
        buf_nx  = msg_data;
        src_nx  = 1'b1;
        mack_nx = 1'b1;
      end else if (tmr_valid) begin
        buf_nx  = tmr_data;
        src_nx  = 1'b0;
        tack_nx = 1'b1;
      end
      mask_nx = blink_mask;
      if (blink_cnt == BL_MAX) begin
        cnt_nx   = '0;
        phase_nx = ~blink_phase;
      end else begin
        cnt_nx = blink_cnt + 1'b1;
      end
    end

    // Outputs are built from the post-edge idx/buffer/blink state so that the
    // first digit of a new frame already reflects what the boundary latched.
    sel_nx = ~(6'b100000 >> idx_nx);
    led_nx = seg_decode(pick_nibble(buf_nx, idx_nx));
    if (phase_nx && |(mask_nx & ~sel_nx)) begin
      led_nx = 8'hFF;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      idx         <= 3'd5;
      frame_buf   <= 24'hAAAAAA;
      mask_buf    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sel         <= '1;
      led         <= '1;
      tmr_ack     <= 1'b0;
      msg_ack     <= 1'b0;
      frame_start <= 1'b0;
      active_src  <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + 1'b1;
      idx         <= idx_nx;
      frame_buf   <= buf_nx;
      mask_buf    <= mask_nx;
      blink_cnt   <= cnt_nx;
      blink_phase <= phase_nx;
      active_src  <= src_nx;
      tmr_ack     <= tack_nx;
      msg_ack     <= mack_nx;
      frame_start <= boundary;
      if (tick) begin
        sel <= sel_nx;
        led <= led_nx;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_sched.sv
// Directed bench for disp_scan_sched with SCAN_DIV=4, BLINK_FRAMES=2;
// tick k after reset release lands on cycle 4k.
module tb_disp_scan_sched;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [23:0] tmr_data;
  logic        tmr_valid;
  logic        tmr_ack;
  logic [23:0] msg_data;
  logic        msg_req;
  logic        msg_ack;
  logic [5:0]  blink_mask;
  logic [5:0]  sel;
  logic [7:0]  led;
  logic        frame_start;
  logic        active_src;

  int n_chk = 0;
  int n_err = 0;
  int cyc_now = 0;

  disp_scan_sched #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clkin(clkin), .rst_n(rst_n),
    .tmr_data(tmr_data), .tmr_valid(tmr_valid), .tmr_ack(tmr_ack),
    .msg_data(msg_data), .msg_req(msg_req), .msg_ack(msg_ack),
    .blink_mask(blink_mask), .sel(sel), .led(led),
    .frame_start(frame_start), .active_src(active_src)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clkin);
    #1;
    cyc_now += n;
  endtask

  task automatic at_tick(input int k);
    adv(4 * k - cyc_now);
  endtask

  logic [5:0] sel_tab [5] = '{6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
  logic [7:0] tmr_led [5] = '{8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
  logic [7:0] msg_led [5] = '{8'hFF, 8'h86, 8'hAB, 8'hA1, 8'hFF};

  initial begin
    rst_n = 1'b0; tmr_data = 24'h123456; tmr_valid = 1'b1;
    msg_data = '0; msg_req = 1'b0; blink_mask = '0;
    #12;
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_led", 32'(led), 32'hFF);
    check("rst_tack", 32'(tmr_ack), 0);
    check("rst_mack", 32'(msg_ack), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_src", 32'(active_src), 0);

    @(negedge clkin); rst_n = 1'b1; cyc_now = 0;
    adv(3);
    check("pre_tick_sel", 32'(sel), 32'h3F);
    check("pre_tick_tack", 32'(tmr_ack), 0);

    // First tick is a frame boundary showing digit1
    at_tick(1);
    check("t1_tack", 32'(tmr_ack), 1);
    check("t1_fs", 32'(frame_start), 1);
    check("t1_sel", 32'(sel), 32'h1F);
    check("t1_led", 32'(led), 32'hF9);
    check("t1_mack", 32'(msg_ack), 0);
    check("t1_src", 32'(active_src), 0);
    adv(1);
    check("t1_tack_drop", 32'(tmr_ack), 0);
    check("t1_fs_drop", 32'(frame_start), 0);
    check("t1_sel_hold", 32'(sel), 32'h1F);
    for (int i = 2; i <= 6; i++) begin
      at_tick(i);
      check("scan_sel", 32'(sel), 32'(sel_tab[i-2]));
      check("scan_led", 32'(led), 32'(tmr_led[i-2]));
    end
    at_tick(7);
    check("wrap_sel", 32'(sel), 32'h1F);
    check("wrap_led", 32'(led), 32'hF9);
    check("wrap_tack", 32'(tmr_ack), 1);

    // Mid-frame data change stays invisible until the next boundary
    at_tick(9);
    check("mid_d3", 32'(led), 32'hB0);
    tmr_data = 24'h999999;
    for (int i = 10; i <= 12; i++) begin
      at_tick(i);
      check("mid_old", 32'(led), 32'(tmr_led[i-8]));
    end
    at_tick(13);
    check("new_d1", 32'(led), 32'h90);
    check("new_tack", 32'(tmr_ack), 1);

    // Simultaneous requests: message wins
    at_tick(15);
    msg_data = 24'hAABCDA; msg_req = 1'b1;
    at_tick(16);
    check("pre_msg_led", 32'(led), 32'h90);
    check("pre_msg_src", 32'(active_src), 0);
    at_tick(19);
    check("msg_mack", 32'(msg_ack), 1);
    check("msg_tack", 32'(tmr_ack), 0);
    check("msg_src", 32'(active_src), 1);
    check("msg_sel", 32'(sel), 32'h1F);
    check("msg_led1", 32'(led), 32'hFF);
    adv(1);
    check("msg_mack_drop", 32'(msg_ack), 0);
    msg_req = 1'b0; tmr_valid = 1'b0;
    for (int i = 20; i <= 24; i++) begin
      at_tick(i);
      check("msg_led", 32'(led), 32'(msg_led[i-20]));
    end

    // No request: frame repeats, no ack, source holds
    at_tick(25);
    check("idle_tack", 32'(tmr_ack), 0);
    check("idle_mack", 32'(msg_ack), 0);
    check("idle_fs", 32'(frame_start), 1);
    check("idle_src", 32'(active_src), 1);
    check("idle_led1", 32'(led), 32'hFF);
    at_tick(27);
    check("idle_led3", 32'(led), 32'h86);

    // Blink digit6
    blink_mask = 6'b000001; tmr_data = 24'h123456; tmr_valid = 1'b1;
    at_tick(31);
    check("bl_tack", 32'(tmr_ack), 1);
    check("bl_src", 32'(active_src), 0);
    check("bl_d1", 32'(led), 32'hF9);
    at_tick(35); check("bl_d5", 32'(led), 32'h92);
    at_tick(36); check("bl_sel6", 32'(sel), 32'h3E);
    check("bl_off_a", 32'(led), 32'hFF);
    at_tick(42); check("bl_off_b", 32'(led), 32'hFF);
    at_tick(48); check("bl_on_a", 32'(led), 32'h82);
    at_tick(54); check("bl_on_b", 32'(led), 32'h82);
    at_tick(60); check("bl_off_c", 32'(led), 32'hFF);

    // Async reset mid-frame at idx=3
    tmr_valid = 1'b0;
    at_tick(64);
    check("pre_rst_sel", 32'(sel), 32'h3B);
    check("pre_rst_led", 32'(led), 32'h99);
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(sel), 32'h3F);
    check("async_led", 32'(led), 32'hFF);
    @(negedge clkin); rst_n = 1'b1; cyc_now = 0;
    at_tick(1);
    check("rr_sel", 32'(sel), 32'h1F);
    check("rr_led", 32'(led), 32'hFF);
    check("rr_fs", 32'(frame_start), 1);
    check("rr_tack", 32'(tmr_ack), 0);
    check("rr_mack", 32'(msg_ack), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
